stage_memory: RTL and testbench
===============================

Name: stage_memory

Overview:
- Memory-access stage of the CPU pipeline. Sits directly downstream of the execute stage and upstream of write-back.
- Consumes execute's registered outputs and performs loads and stores on a req/gnt/rvalid data-memory port. Handles byte lanes, load extension and misalignment detection.
- Provides async forwarding outputs and a registered pipeline output to write-back.
- Stalls the upstream pipeline while memory is busy.

Parameters:
- None. All types and constants (word_t, regaddr_t, ma_mode_t, ma_size_t, wb_src_t, NOP_*) come from common/cpu_common.

Ports:
- clk_i  in  1  clock. Single clock domain.
- reset_i  in  1  asynchronous, active-high reset.
- pc_i, ir_i  in  32 each  program counter and instruction from execute.
- ma_addr_i  in  32  byte address of the access.
- ma_mode_i  in  ma_mode_t  MA_X (none), MA_LOAD, MA_STORE.
- ma_size_i  in  ma_size_t  MA_SIZE_B, MA_SIZE_H, MA_SIZE_W, MA_SIZE_BU, MA_SIZE_HU.
- ma_data_i  in  32  store data.
- wb_src_i  in  wb_src_t  write-back source (WB_SRC_MEM means load result).
- wb_data_i  in  32  non-memory write-back data.
- wb_valid_i  in  1  write-back valid.
- dmem_req_o  out  1  access request.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  32  word-aligned address ({ma_addr_i[31:2],2'b00}).
- dmem_wmask_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted this cycle.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  32  read data.
- stall_async_o  out  1  upstream must hold its outputs this cycle.
- wb_addr_async_o  out  5  forwarding address (ir[11:7]).
- wb_data_async_o  out  32  forwarding data.
- wb_ready_async_o  out  1  forwarding data is final.
- wb_valid_async_o  out  1  forwarding entry valid.
- empty_async_o  out  1  stage holds no instruction.
- misaligned_o  out  1  registered one-cycle misaligned-access flag.
- pc_o, ir_o  out  32 each  pipeline output to write-back.
- wb_addr_o  out  5  pipeline output write-back address.
- wb_data_o  out  32  pipeline output write-back data.
- wb_valid_o  out  1  pipeline output write-back valid.

Behaviour:
- Reset:
  - State goes to READY.
  - pc_o=NOP_PC, ir_o=NOP_IR, wb_addr_o=0, wb_data_o=0, wb_valid_o=NOP_WB_VALID, misaligned_o=0.
  - While reset_i is high, dmem_req_o=0 and stall_async_o=0.
- Offset and misalignment:
  - off = ma_addr_i[1:0].
  - Misaligned means: H/HU with off[0]=1, or W with off!=0.
- State READY:
  - dmem_req_o = (ma_mode_i != MA_X) && !misaligned.
  - dmem_we_o = (ma_mode_i == MA_STORE).
- Store lanes:
  - B: wdata={4{d[7:0]}}, wmask=4'b0001<<off.
  - H: wdata={2{d[15:0]}}, wmask=4'b0011<<off.
  - W: wdata=d, wmask=4'b1111.
  - For loads, wmask=0.
- Request pending without grant (req && !gnt):
  - stall_async_o=1.
  - Pipeline output loads a bubble: NOP_PC, NOP_IR, wb_valid 0.
  - Upstream holds its outputs, so the request persists.
- Store granted: output registers capture pc/ir/wb fields from the inputs at the next edge. Latency is 1 cycle.
- Load granted:
  - Latch pc, ir, size and off into internal registers.
  - Go to WAIT_RESP.
  - The output register captures a bubble.
- State WAIT_RESP:
  - stall_async_o=1 and dmem_req_o=0.
  - Forwarding outputs describe the held load: addr=ir[11:7], valid=1, ready=dmem_rvalid_i, data=extracted value.
  - On dmem_rvalid_i: output registers capture the held pc/ir, wb_addr, extracted data and wb_valid=1, then the state returns to READY.
  - Upstream is released the cycle after rvalid.
- Load extraction: x = dmem_rdata_i >> (8*off).
  - B: sign-extend x[7:0].
  - BU: zero-extend x[7:0].
  - H: sign-extend x[15:0].
  - HU: zero-extend x[15:0].
  - W: x.
- Non-memory instruction (MA_X) in READY:
  - No stall.
  - Forwarding: data=wb_data_i, ready=1, valid=wb_valid_i.
  - Pipeline output captures it in 1 cycle.
- Forwarding in READY for a load before grant: ready=0.
- Misaligned access:
  - No request is issued and the instruction passes through with wb_valid forced to 0.
  - misaligned_o=1 for exactly one cycle, aligned with pc_o of that instruction.
- empty_async_o = (state==READY && pc_i==NOP_PC).
- Stray response: dmem_rvalid_i in READY is ignored.
- Reset mid-operation: reset during WAIT_RESP returns the stage to READY. A response arriving after reset is ignored.

Test Plan:
- MA_X pass-through: pc=0x100, wb_data=0x55, wb_valid=1 -> forwarding data 0x55, ready=1; next cycle pc_o=0x100, wb_data_o=0x55, wb_valid_o=1; no dmem_req.
- SB: addr=0x2003, data=0x000000A5, gnt same cycle -> req=1, we=1, dmem_addr=0x2000, wmask=4'b1000, wdata=0xA5A5A5A5, no stall.
- LB / LBU: addr=0x2001, gnt at T, rvalid at T+3 with rdata=0x1234F0AA -> stall high T..T+3.
  - LB: wb_data_o=0xFFFFFFF0 at T+4. LBU with the same data: 0x000000F0.
  - Bubbles on the output during stall.
- Delayed grant: LW at addr 0x3000 with gnt held low for 2 cycles -> req held 3 cycles, stall held, then normal load completion.
- Misaligned LH at 0x3001 -> no req; misaligned_o pulses 1 cycle with pc_o of that instruction; wb_valid_o=0.
- Reset asserted in WAIT_RESP, rvalid one cycle after release -> outputs reset to NOP, rvalid ignored, next MA_X instruction flows normally.

Source files
------------

// File: rtl/stage_memory.sv
// rtl/stage_memory.sv - memory-access pipeline stage: dmem loads/stores, byte lanes, load extension, forwarding
package cpu_common;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regaddr_t;
  typedef enum logic [1:0] {MA_X = 2'd0, MA_LOAD = 2'd1, MA_STORE = 2'd2} ma_mode_t;
  typedef enum logic [2:0] {MA_SIZE_B, MA_SIZE_H, MA_SIZE_W, MA_SIZE_BU, MA_SIZE_HU} ma_size_t;
  typedef enum logic [1:0] {WB_SRC_ALU, WB_SRC_MEM, WB_SRC_PC} wb_src_t;
  localparam word_t NOP_PC       = 32'h0000_0000;
  localparam word_t NOP_IR       = 32'h0000_0013;
  localparam logic  NOP_WB_VALID = 1'b0;
endpackage

module stage_memory
  import cpu_common::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  word_t    pc_i,
  input  word_t    ir_i,
  input  word_t    ma_addr_i,
  input  ma_mode_t ma_mode_i,
  input  ma_size_t ma_size_i,
  input  word_t    ma_data_i,
  input  wb_src_t  wb_src_i,
  input  word_t    wb_data_i,
  input  logic     wb_valid_i,
  output logic     dmem_req_o,
  output logic     dmem_we_o,
  output word_t    dmem_addr_o,
  output logic [3:0] dmem_wmask_o,
  output word_t    dmem_wdata_o,
  input  logic     dmem_gnt_i,
  input  logic     dmem_rvalid_i,
  input  word_t    dmem_rdata_i,
  output logic     stall_async_o,
  output regaddr_t wb_addr_async_o,
  output word_t    wb_data_async_o,
  output logic     wb_ready_async_o,
  output logic     wb_valid_async_o,
  output logic     empty_async_o,
  output logic     misaligned_o,
  output word_t    pc_o,
  output word_t    ir_o,
  output regaddr_t wb_addr_o,
  output word_t    wb_data_o,
  output logic     wb_valid_o
);

  typedef enum logic {READY, WAIT_RESP} state_t;

  state_t     state_q, state_d;
  logic [1:0] off, off_q;
  ma_size_t   size_q;
  word_t      hold_pc_q, hold_ir_q;
  logic       misaligned;
  logic       latch_load;
  word_t      shifted, load_data;

  word_t      nxt_pc, nxt_ir, nxt_wb_data;
  regaddr_t   nxt_wb_addr;
  logic       nxt_wb_valid, nxt_misaligned;

  assign off         = ma_addr_i[1:0];
  assign dmem_addr_o = {ma_addr_i[31:2], 2'b00};

  always_comb begin
    misaligned = 1'b0;
    if (ma_mode_i != MA_X) begin
      case (ma_size_i)
        MA_SIZE_H, MA_SIZE_HU: misaligned = off[0];
        MA_SIZE_W:             misaligned = (off != 2'b00);
        default:               misaligned = 1'b0;
      endcase
    end
  end

  // Store data is replicated across lanes so the mask alone selects the target bytes.
  always_comb begin
    dmem_wdata_o = ma_data_i;
    dmem_wmask_o = 4'b1111;
    case (ma_size_i)
      MA_SIZE_B, MA_SIZE_BU: begin
        dmem_wdata_o = {4{ma_data_i[7:0]}};
        dmem_wmask_o = 4'b0001 << off;
      end
      MA_SIZE_H, MA_SIZE_HU: begin
        dmem_wdata_o = {2{ma_data_i[15:0]}};
        dmem_wmask_o = 4'b0011 << off;
      end
      default: begin
        dmem_wdata_o = ma_data_i;
        dmem_wmask_o = 4'b1111;
      end
    endcase
    if (ma_mode_i != MA_STORE) dmem_wmask_o = 4'b0000;
  end

  always_comb begin
    shifted   = dmem_rdata_i >> {off_q, 3'b000};
    load_data = shifted;
    case (size_q)
      MA_SIZE_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      MA_SIZE_BU: load_data = {24'h0, shifted[7:0]};
      MA_SIZE_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      MA_SIZE_HU: load_data = {16'h0, shifted[15:0]};
      default:    load_data = shifted;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    dmem_req_o       = 1'b0;
    dmem_we_o        = 1'b0;
    stall_async_o    = 1'b0;
    latch_load       = 1'b0;
    wb_addr_async_o  = ir_i[11:7];
    wb_data_async_o  = wb_data_i;
    wb_ready_async_o = !(ma_mode_i == MA_LOAD || wb_src_i == WB_SRC_MEM);
    wb_valid_async_o = wb_valid_i && !misaligned;
    nxt_pc           = NOP_PC;
    nxt_ir           = NOP_IR;
    nxt_wb_addr      = '0;
    nxt_wb_data      = '0;
    nxt_wb_valid     = 1'b0;
    nxt_misaligned   = 1'b0;
    case (state_q)
      READY: begin
        dmem_req_o = (ma_mode_i != MA_X) && !misaligned;
        dmem_we_o  = (ma_mode_i == MA_STORE);
        if (dmem_req_o && !dmem_gnt_i) begin
          stall_async_o = 1'b1;
        end else if (dmem_req_o && ma_mode_i == MA_LOAD) begin
          stall_async_o = 1'b1;
          latch_load    = 1'b1;
          state_d       = WAIT_RESP;
        end else begin
          nxt_pc         = pc_i;
          nxt_ir         = ir_i;
          nxt_wb_addr    = ir_i[11:7];
          nxt_wb_data    = wb_data_i;
          nxt_wb_valid   = wb_valid_i && !misaligned;
          nxt_misaligned = misaligned;
        end
      end
      WAIT_RESP: begin
        stall_async_o    = 1'b1;
        wb_addr_async_o  = hold_ir_q[11:7];
        wb_data_async_o  = load_data;
        wb_ready_async_o = dmem_rvalid_i;
        wb_valid_async_o = 1'b1;
        if (dmem_rvalid_i) begin
          nxt_pc       = hold_pc_q;
          nxt_ir       = hold_ir_q;
          nxt_wb_addr  = hold_ir_q[11:7];
          nxt_wb_data  = load_data;
          nxt_wb_valid = 1'b1;
          state_d      = READY;
        end
      end
      default: state_d = READY;
    endcase
    if (reset_i) begin
      dmem_req_o    = 1'b0;
      stall_async_o = 1'b0;
    end
  end

  assign empty_async_o = (state_q == READY) && (pc_i == NOP_PC);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= READY;
      pc_o         <= NOP_PC;
      ir_o         <= NOP_IR;
      wb_addr_o    <= '0;
      wb_data_o    <= '0;
      wb_valid_o   <= NOP_WB_VALID;
      misaligned_o <= 1'b0;
      hold_pc_q    <= NOP_PC;
      hold_ir_q    <= NOP_IR;
      size_q       <= MA_SIZE_W;
      off_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      pc_o         <= nxt_pc;
      ir_o         <= nxt_ir;
      wb_addr_o    <= nxt_wb_addr;
      wb_data_o    <= nxt_wb_data;
      wb_valid_o   <= nxt_wb_valid;
      misaligned_o <= nxt_misaligned;
      if (latch_load) begin
        hold_pc_q <= pc_i;
        hold_ir_q <= ir_i;
        size_q    <= ma_size_i;
        off_q     <= off;
      end
    end
  end

endmodule

// File: tb/tb_stage_memory.sv
// tb/tb_stage_memory.sv - self-checking bench for stage_memory
module tb_stage_memory;
  import cpu_common::*;

  logic       clk_i = 1'b0;
  logic       reset_i;
  word_t      pc_i, ir_i, ma_addr_i, ma_data_i, wb_data_i, dmem_rdata_i;
  ma_mode_t   ma_mode_i;
  ma_size_t   ma_size_i;
  wb_src_t    wb_src_i;
  logic       wb_valid_i, dmem_gnt_i, dmem_rvalid_i;
  logic       dmem_req_o, dmem_we_o;
  word_t      dmem_addr_o, dmem_wdata_o;
  logic [3:0] dmem_wmask_o;
  logic       stall_async_o, wb_ready_async_o, wb_valid_async_o, empty_async_o, misaligned_o;
  regaddr_t   wb_addr_async_o, wb_addr_o;
  word_t      wb_data_async_o, pc_o, ir_o, wb_data_o;
  logic       wb_valid_o;

  int checks = 0;
  int errors = 0;
  int seq    = 0;

  stage_memory dut (
    .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_i), .ir_i(ir_i),
    .ma_addr_i(ma_addr_i), .ma_mode_i(ma_mode_i), .ma_size_i(ma_size_i),
    .ma_data_i(ma_data_i), .wb_src_i(wb_src_i), .wb_data_i(wb_data_i),
    .wb_valid_i(wb_valid_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wmask_o(dmem_wmask_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_async_o(stall_async_o), .wb_addr_async_o(wb_addr_async_o),
    .wb_data_async_o(wb_data_async_o), .wb_ready_async_o(wb_ready_async_o),
    .wb_valid_async_o(wb_valid_async_o), .empty_async_o(empty_async_o),
    .misaligned_o(misaligned_o), .pc_o(pc_o), .ir_o(ir_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_valid_o(wb_valid_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: accesses described as byte counts and byte lanes.
  function automatic int nbytes(input ma_size_t s);
    if (s == MA_SIZE_B || s == MA_SIZE_BU) return 1;
    if (s == MA_SIZE_H || s == MA_SIZE_HU) return 2;
    return 4;
  endfunction

  function automatic bit ref_misaligned(input ma_size_t s, input logic [1:0] off);
    return (int'(off) % nbytes(s)) != 0;
  endfunction

  function automatic logic [3:0] ref_wmask(input ma_size_t s, input logic [1:0] off);
    logic [3:0] m;
    int o;
    int nb;
    o = int'(off);
    nb = nbytes(s);
    for (int i = 0; i < 4; i++) m[i] = (i >= o) && (i < o + nb);
    return m;
  endfunction

  function automatic word_t ref_wdata(input ma_size_t s, input word_t d);
    word_t r;
    int nb;
    nb = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic word_t ref_load(input ma_size_t s, input word_t rdata, input logic [1:0] off);
    word_t v;
    int nb;
    nb = nbytes(s);
    v = '0;
    for (int k = 0; k < nb; k++) v[8*k +: 8] = rdata[8*(int'(off) + k) +: 8];
    if ((s == MA_SIZE_B || s == MA_SIZE_H) && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  function automatic word_t mk_ir(input logic [4:0] rd);
    word_t r;
    r = $urandom;
    r[11:7] = rd;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input word_t pc, input word_t ir, input word_t addr, input ma_mode_t m,
                       input ma_size_t s, input word_t d, input word_t wbd, input logic wbv);
    pc_i = pc; ir_i = ir; ma_addr_i = addr; ma_mode_i = m; ma_size_i = s;
    ma_data_i = d; wb_data_i = wbd; wb_valid_i = wbv;
    wb_src_i = (m == MA_LOAD) ? WB_SRC_MEM : WB_SRC_ALU;
  endtask

  task automatic idle();
    drive(NOP_PC, NOP_IR, 32'h0, MA_X, MA_SIZE_W, 32'h0, 32'h0, 1'b0);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    drive(32'h200, mk_ir(5'd4), 32'h2000, MA_LOAD, MA_SIZE_W, 32'h0, 32'h0, 1'b1);
    dmem_gnt_i = 1'b1;
    tick();
    checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req_o); end
    checks++; if (stall_async_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_async_o); end
    checks++; if (pc_o !== NOP_PC || ir_o !== NOP_IR) begin errors++; $display("FAIL reset_pc_ir: got %h/%h want %h/%h", pc_o, ir_o, NOP_PC, NOP_IR); end
    checks++; if (wb_valid_o !== NOP_WB_VALID || wb_data_o !== 32'h0 || wb_addr_o !== 5'h0) begin
      errors++; $display("FAIL reset_wb: got v=%b d=%h a=%h want 0/0/0", wb_valid_o, wb_data_o, wb_addr_o); end
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned_o); end
    idle();
    reset_i = 1'b0;
    #1;
    checks++; if (empty_async_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty_async_o); end
    tick();
  endtask

  task automatic test_passthrough(input word_t pc, input word_t wbd, input logic [4:0] rd, input logic wbv);
    word_t ir;
    ir = mk_ir(rd);
    drive(pc, ir, $urandom, MA_X, MA_SIZE_W, $urandom, wbd, wbv);
    #1;
    checks++; if (wb_data_async_o !== wbd || wb_ready_async_o !== 1'b1 || wb_valid_async_o !== wbv || wb_addr_async_o !== rd) begin
      errors++; $display("FAIL pass_fwd: got d=%h r=%b v=%b a=%h want %h/1/%b/%h", wb_data_async_o, wb_ready_async_o, wb_valid_async_o, wb_addr_async_o, wbd, wbv, rd); end
    checks++; if (dmem_req_o !== 1'b0 || stall_async_o !== 1'b0 || empty_async_o !== 1'b0) begin
      errors++; $display("FAIL pass_req_stall: got req=%b stall=%b empty=%b want 0/0/0", dmem_req_o, stall_async_o, empty_async_o); end
    tick();
    checks++; if (pc_o !== pc || ir_o !== ir || wb_data_o !== wbd || wb_valid_o !== wbv || wb_addr_o !== rd) begin
      errors++; $display("FAIL pass_out: got pc=%h d=%h v=%b a=%h want %h/%h/%b/%h", pc_o, wb_data_o, wb_valid_o, wb_addr_o, pc, wbd, wbv, rd); end
  endtask

  task automatic test_store(input word_t pc, input word_t addr, input ma_size_t s, input word_t d, input int gnt_delay);
    word_t ir;
    ir = mk_ir(5'($urandom_range(0, 31)));
    drive(pc, ir, addr, MA_STORE, s, d, 32'h0, 1'b0);
    for (int i = 0; i < gnt_delay; i++) begin
      #1;
      checks++; if (dmem_req_o !== 1'b1 || stall_async_o !== 1'b1) begin
        errors++; $display("FAIL st_wait_gnt: got req=%b stall=%b want 1/1", dmem_req_o, stall_async_o); end
      tick();
      checks++; if (pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin
        errors++; $display("FAIL st_bubble: got pc=%h v=%b want %h/0", pc_o, wb_valid_o, NOP_PC); end
    end
    dmem_gnt_i = 1'b1;
    #1;
    checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || stall_async_o !== 1'b0) begin
      errors++; $display("FAIL st_req: got req=%b we=%b stall=%b want 1/1/0", dmem_req_o, dmem_we_o, stall_async_o); end
    checks++; if (dmem_addr_o !== (addr & 32'hFFFF_FFFC)) begin
      errors++; $display("FAIL st_addr: got %h want %h", dmem_addr_o, addr & 32'hFFFF_FFFC); end
    checks++; if (dmem_wmask_o !== ref_wmask(s, addr[1:0]) || dmem_wdata_o !== ref_wdata(s, d)) begin
      errors++; $display("FAIL st_lanes: got m=%b d=%h want %b/%h", dmem_wmask_o, dmem_wdata_o, ref_wmask(s, addr[1:0]), ref_wdata(s, d)); end
    tick();
    dmem_gnt_i = 1'b0;
    checks++; if (pc_o !== pc || ir_o !== ir || misaligned_o !== 1'b0) begin
      errors++; $display("FAIL st_out: got pc=%h ir=%h mis=%b want %h/%h/0", pc_o, ir_o, misaligned_o, pc, ir); end
  endtask

  task automatic test_load(input word_t pc, input word_t addr, input ma_size_t s, input word_t rdata,
                           input int gnt_delay, input int resp_delay);
    logic [4:0] rd;
    word_t ir, exp;
    rd  = 5'($urandom_range(1, 31));
    ir  = mk_ir(rd);
    exp = ref_load(s, rdata, addr[1:0]);
    drive(pc, ir, addr, MA_LOAD, s, $urandom, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < gnt_delay; i++) begin
      #1;
      checks++; if (dmem_req_o !== 1'b1 || stall_async_o !== 1'b1 || wb_ready_async_o !== 1'b0) begin
        errors++; $display("FAIL ld_wait_gnt: got req=%b stall=%b rdy=%b want 1/1/0", dmem_req_o, stall_async_o, wb_ready_async_o); end
      tick();
      checks++; if (pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin
        errors++; $display("FAIL ld_bubble_gnt: got pc=%h v=%b want %h/0", pc_o, wb_valid_o, NOP_PC); end
    end
    dmem_gnt_i = 1'b1;
    #1;
    checks++; if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_wmask_o !== 4'b0000 || stall_async_o !== 1'b1) begin
      errors++; $display("FAIL ld_req: got req=%b we=%b m=%b stall=%b want 1/0/0000/1", dmem_req_o, dmem_we_o, dmem_wmask_o, stall_async_o); end
    checks++; if (dmem_addr_o !== (addr & 32'hFFFF_FFFC)) begin
      errors++; $display("FAIL ld_addr: got %h want %h", dmem_addr_o, addr & 32'hFFFF_FFFC); end
    tick();
    dmem_gnt_i = 1'b0;
    checks++; if (pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL ld_bubble_grant: got pc=%h v=%b want %h/0", pc_o, wb_valid_o, NOP_PC); end
    for (int i = 0; i < resp_delay; i++) begin
      dmem_rdata_i = $urandom;
      #1;
      checks++; if (dmem_req_o !== 1'b0 || stall_async_o !== 1'b1 || wb_valid_async_o !== 1'b1 || wb_ready_async_o !== 1'b0 || wb_addr_async_o !== rd) begin
        errors++; $display("FAIL ld_wait_resp: got req=%b stall=%b v=%b r=%b a=%h want 0/1/1/0/%h", dmem_req_o, stall_async_o, wb_valid_async_o, wb_ready_async_o, wb_addr_async_o, rd); end
      tick();
      checks++; if (pc_o !== NOP_PC || wb_valid_o !== 1'b0) begin
        errors++; $display("FAIL ld_bubble_resp: got pc=%h v=%b want %h/0", pc_o, wb_valid_o, NOP_PC); end
    end
    dmem_rdata_i = rdata;
    dmem_rvalid_i = 1'b1;
    #1;
    checks++; if (stall_async_o !== 1'b1 || wb_ready_async_o !== 1'b1 || wb_data_async_o !== exp) begin
      errors++; $display("FAIL ld_fwd: got stall=%b r=%b d=%h want 1/1/%h", stall_async_o, wb_ready_async_o, wb_data_async_o, exp); end
    tick();
    dmem_rvalid_i = 1'b0;
    checks++; if (pc_o !== pc || ir_o !== ir || wb_data_o !== exp || wb_valid_o !== 1'b1 || wb_addr_o !== rd) begin
      errors++; $display("FAIL ld_out: got pc=%h d=%h v=%b a=%h want %h/%h/1/%h", pc_o, wb_data_o, wb_valid_o, wb_addr_o, pc, exp, rd); end
  endtask

  task automatic test_misaligned(input word_t pc, input word_t addr, input ma_mode_t m, input ma_size_t s);
    drive(pc, mk_ir(5'd7), addr, m, s, $urandom, $urandom, 1'b1);
    dmem_gnt_i = 1'b1;
    #1;
    checks++; if (dmem_req_o !== 1'b0 || stall_async_o !== 1'b0) begin
      errors++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", dmem_req_o, stall_async_o); end
    tick();
    dmem_gnt_i = 1'b0;
    checks++; if (misaligned_o !== 1'b1 || pc_o !== pc || wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL mis_out: got mis=%b pc=%h v=%b want 1/%h/0", misaligned_o, pc_o, wb_valid_o, pc); end
    idle();
    tick();
    checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL mis_pulse: got %b want 0", misaligned_o); end
  endtask

  task automatic test_reset_mid();
    drive(32'h400, mk_ir(5'd9), 32'h3000, MA_LOAD, MA_SIZE_W, 32'h0, 32'h0, 1'b1);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    #1;
    checks++; if (stall_async_o !== 1'b1) begin errors++; $display("FAIL rm_wait: got stall=%b want 1", stall_async_o); end
    reset_i = 1'b1;
    #1;
    checks++; if (stall_async_o !== 1'b0 || dmem_req_o !== 1'b0 || pc_o !== NOP_PC) begin
      errors++; $display("FAIL rm_async: got stall=%b req=%b pc=%h want 0/0/%h", stall_async_o, dmem_req_o, pc_o, NOP_PC); end
    tick();
    idle();
    reset_i = 1'b0;
    tick();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFE_F00D;
    #1;
    checks++; if (stall_async_o !== 1'b0) begin errors++; $display("FAIL rm_stray_stall: got %b want 0", stall_async_o); end
    tick();
    dmem_rvalid_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b0 || pc_o !== NOP_PC) begin
      errors++; $display("FAIL rm_stray_out: got v=%b pc=%h want 0/%h", wb_valid_o, pc_o, NOP_PC); end
    test_passthrough(32'h404, 32'h1234_5678, 5'd11, 1'b1);
  endtask

  task automatic test_random(input int n);
    ma_size_t sizes[5];
    ma_mode_t m;
    ma_size_t s;
    logic [1:0] off;
    word_t pc, addr;
    sizes = '{MA_SIZE_B, MA_SIZE_H, MA_SIZE_W, MA_SIZE_BU, MA_SIZE_HU};
    for (int i = 0; i < n; i++) begin
      seq++;
      pc   = 32'h1000 + 32'(seq) * 4;
      s    = sizes[$urandom_range(0, 4)];
      off  = 2'($urandom_range(0, 3));
      addr = {$urandom_range(0, 32'h3FFF_FFFF), off};
      case ($urandom_range(0, 2))
        0: m = MA_X;
        1: m = MA_LOAD;
        default: m = MA_STORE;
      endcase
      if (m == MA_X)
        test_passthrough(pc, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else if (ref_misaligned(s, off))
        test_misaligned(pc, addr, m, s);
      else if (m == MA_LOAD)
        test_load(pc, addr, s, $urandom, $urandom_range(0, 2), $urandom_range(0, 3));
      else
        test_store(pc, addr, s, $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    reset_i = 1'b1;
    idle();
    test_reset();
    test_passthrough(32'h100, 32'h55, 5'd3, 1'b1);
    test_store(32'h104, 32'h2003, MA_SIZE_B, 32'h0000_00A5, 0);
    test_load(32'h108, 32'h2001, MA_SIZE_B, 32'h1234_F0AA, 0, 2);
    test_load(32'h10C, 32'h2001, MA_SIZE_BU, 32'h1234_F0AA, 0, 2);
    test_load(32'h110, 32'h3000, MA_SIZE_W, 32'h89AB_CDEF, 2, 1);
    test_misaligned(32'h114, 32'h3001, MA_LOAD, MA_SIZE_H);
    test_reset_mid();
    test_random(80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
